// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// ram_arbiter_pkg : shared types and defaults for the RAM arbiter slice
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SCRUB = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ============================================================================
// ram_arbiter_if : requester bus plus RAM-side signals of the RAM arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          clr_req;
  logic                          clr_busy;
  logic                          clr_done;
  logic                          ram_cs;
  logic                          ram_wen;
  logic                          ram_ren;
  logic [ADDR_WIDTH-1:0]         ram_waddr;
  logic [ADDR_WIDTH-1:0]         ram_raddr;
  logic [DATA_WIDTH-1:0]         ram_wdata;
  logic [DATA_WIDTH-1:0]         ram_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, clr_req, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, clr_busy, clr_done,
           ram_cs, ram_wen, ram_ren, ram_waddr, ram_raddr, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, clr_req, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, clr_busy, clr_done,
           ram_cs, ram_wen, ram_ren, ram_waddr, ram_raddr, ram_wdata
  );

endinterface

`default_nettype wire

// File: rtl/ram_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin arbiter, winner is first requester after pointer
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0]               req_i,
  input  logic                       en_i,
  output logic [N-1:0]               gnt_o,
  output logic [ptr_width(N)-1:0]    gnt_idx_o
);

  localparam int PTR_W = ptr_width(N);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % N);
      if (!found && en_i && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
    ptr_d = found ? gnt_idx_o : ptr_q;
  end

  // Reset to N-1 so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : shares a two-port RAM among requesters, with zero-fill scrub
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  localparam int IDX_W = ptr_width(NUM_REQ);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic                  clr_done_q, clr_done_d;

  logic                  idle;
  logic                  scrub_last;
  logic [NUM_REQ-1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  logic                  ram_cs, ram_wen, ram_ren;
  logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  assign idle       = (state_q == ST_IDLE);
  assign scrub_last = (cnt_q == ADDR_WIDTH'(DEPTH - 1));
  assign wr_req     = bus.req_valid & bus.req_we;
  assign rd_req     = bus.req_valid & ~bus.req_we;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (wr_req),
    .en_i      (idle),
    .gnt_o     (wr_gnt),
    .gnt_idx_o (wr_idx)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (rd_req),
    .en_i      (idle),
    .gnt_o     (rd_gnt),
    .gnt_idx_o (rd_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = ST_SCRUB;
        end
      end
      ST_SCRUB: begin
        if (scrub_last) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    ram_wen       = 1'b0;
    ram_ren       = 1'b0;
    ram_waddr     = '0;
    ram_raddr     = '0;
    ram_wdata     = '0;
    if (!idle) begin
      ram_wen   = 1'b1;
      ram_waddr = cnt_q;
    end else begin
      bus.req_ready = wr_gnt | rd_gnt;
      if (|wr_gnt) begin
        ram_wen   = 1'b1;
        ram_waddr = bus.req_addr[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata = bus.req_wdata[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
      if (|rd_gnt) begin
        ram_ren   = 1'b1;
        ram_raddr = bus.req_addr[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    ram_cs = ram_wen | ram_ren;
  end

  assign bus.ram_cs    = ram_cs;
  assign bus.ram_wen   = ram_wen;
  assign bus.ram_ren   = ram_ren;
  assign bus.ram_waddr = ram_waddr;
  assign bus.ram_raddr = ram_raddr;
  assign bus.ram_wdata = ram_wdata;

  // Read data is only driven while a response strobe is up, so idle outputs stay 0.
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = (|rsp_valid_q) ? bus.ram_rdata : '0;
  assign bus.clr_busy  = !idle;
  assign bus.clr_done  = clr_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rd_gnt;
      clr_done_q  <= clr_done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter : vector table plus directed scrub/reset sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int NVEC       = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ram_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  ram_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Two-port RAM with registered read; a same-cycle write is not seen by the read.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
    if (bus.ram_cs && bus.ram_ren) ram_q <= mem[bus.ram_raddr];
  end
  assign bus.ram_rdata = ram_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v, we;
    logic [3:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] e_rdy;
    logic       e_wen, e_ren;
    logic [3:0] e_wa, e_ra;
    logic [7:0] e_wd;
    logic [1:0] e_rsp;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vt [NVEC];

  function automatic vec_t mk(input logic [1:0] v, we, input logic [3:0] a0, a1,
                              input logic [7:0] d0, d1, input logic [1:0] rdy,
                              input logic wen, ren, input logic [3:0] wa, ra,
                              input logic [7:0] wd, input logic [1:0] rsp,
                              input logic [7:0] rd);
    vec_t r;
    r.v = v; r.we = we; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1;
    r.e_rdy = rdy; r.e_wen = wen; r.e_ren = ren; r.e_wa = wa; r.e_ra = ra;
    r.e_wd = wd; r.e_rsp = rsp; r.e_rd = rd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, we, input logic [3:0] a0, a1,
                       input logic [7:0] d0, d1);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
  endtask

  task automatic go_idle();
    drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ff();
    for (int k = 0; k < DEPTH; k++) begin
      drive(2'b01, 2'b01, 4'(k), 4'h0, 8'hFF, 8'h00);
      next_cycle();
    end
    go_idle();
  endtask

  // Reads every address through requester 0; address < split expects lo, else hi.
  task automatic read_all(input int split, input logic [7:0] lo, input logic [7:0] hi);
    for (int k = 0; k <= DEPTH; k++) begin
      if (k < DEPTH) drive(2'b01, 2'b00, 4'(k), 4'h0, 8'h00, 8'h00);
      else go_idle();
      @(negedge clk);
      if (k > 0) begin
        chk("scan_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("scan_rdata", 32'(bus.rsp_rdata), 32'((k - 1 < split) ? lo : hi));
      end
      next_cycle();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.clr_req = 1'b0;
    go_idle();

    vt[0]  = mk(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 4'h0, 8'h00, 2'b00, 8'h00);
    vt[1]  = mk(2'b01, 2'b01, 4'h3, 4'h0, 8'hA5, 8'h00, 2'b01, 1, 0, 4'h3, 4'h0, 8'hA5, 2'b00, 8'h00);
    vt[2]  = mk(2'b01, 2'b00, 4'h3, 4'h0, 8'h00, 8'h00, 2'b01, 0, 1, 4'h0, 4'h3, 8'h00, 2'b00, 8'h00);
    vt[3]  = mk(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 4'h0, 8'h00, 2'b01, 8'hA5);
    vt[4]  = mk(2'b11, 2'b01, 4'h5, 4'h5, 8'h11, 8'h00, 2'b11, 1, 1, 4'h5, 4'h5, 8'h11, 2'b00, 8'h00);
    vt[5]  = mk(2'b10, 2'b00, 4'h0, 4'h5, 8'h00, 8'h00, 2'b10, 0, 1, 4'h0, 4'h5, 8'h00, 2'b10, 8'h00);
    vt[6]  = mk(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 4'h0, 8'h00, 2'b10, 8'h11);
    vt[7]  = mk(2'b11, 2'b00, 4'h3, 4'h5, 8'h00, 8'h00, 2'b01, 0, 1, 4'h0, 4'h3, 8'h00, 2'b00, 8'h00);
    vt[8]  = mk(2'b11, 2'b00, 4'h3, 4'h5, 8'h00, 8'h00, 2'b10, 0, 1, 4'h0, 4'h5, 8'h00, 2'b01, 8'hA5);
    vt[9]  = mk(2'b11, 2'b00, 4'h3, 4'h5, 8'h00, 8'h00, 2'b01, 0, 1, 4'h0, 4'h3, 8'h00, 2'b10, 8'h11);
    vt[10] = mk(2'b11, 2'b00, 4'h3, 4'h5, 8'h00, 8'h00, 2'b10, 0, 1, 4'h0, 4'h5, 8'h00, 2'b01, 8'hA5);
    vt[11] = mk(2'b11, 2'b00, 4'h3, 4'h5, 8'h00, 8'h00, 2'b01, 0, 1, 4'h0, 4'h3, 8'h00, 2'b10, 8'h11);
    vt[12] = mk(2'b11, 2'b00, 4'h3, 4'h5, 8'h00, 8'h00, 2'b10, 0, 1, 4'h0, 4'h5, 8'h00, 2'b01, 8'hA5);
    vt[13] = mk(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 0, 0, 4'h0, 4'h0, 8'h00, 2'b10, 8'h11);
    vt[14] = mk(2'b11, 2'b11, 4'h1, 4'h2, 8'h22, 8'h33, 2'b10, 1, 0, 4'h2, 4'h0, 8'h33, 2'b00, 8'h00);
    vt[15] = mk(2'b11, 2'b11, 4'h1, 4'h2, 8'h22, 8'h33, 2'b01, 1, 0, 4'h1, 4'h0, 8'h22, 2'b00, 8'h00);

    // Reset state, then a pending read response killed by a mid-cycle reset.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_clr_busy", 32'(bus.clr_busy), 32'h0);
    chk("rst_clr_done", 32'(bus.clr_done), 32'h0);
    chk("rst_ram_cs", 32'(bus.ram_cs), 32'h0);
    next_cycle();
    drive(2'b10, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    next_cycle();
    go_idle();
    #1 chk("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("async_ram_cs", 32'(bus.ram_cs), 32'h0);
    chk("async_ready", 32'(bus.req_ready), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_ram_cs", 32'(bus.ram_cs), 32'h0);
      chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      next_cycle();
    end

    // Single op, parallel ports and round-robin table.
    for (int i = 0; i < NVEC; i++) begin
      drive(vt[i].v, vt[i].we, vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d_wen", i), 32'(bus.ram_wen), 32'(vt[i].e_wen));
      chk($sformatf("v%0d_ren", i), 32'(bus.ram_ren), 32'(vt[i].e_ren));
      chk($sformatf("v%0d_cs", i), 32'(bus.ram_cs), 32'(vt[i].e_wen | vt[i].e_ren));
      chk($sformatf("v%0d_waddr", i), 32'(bus.ram_waddr), 32'(vt[i].e_wa));
      chk($sformatf("v%0d_raddr", i), 32'(bus.ram_raddr), 32'(vt[i].e_ra));
      chk($sformatf("v%0d_wdata", i), 32'(bus.ram_wdata), 32'(vt[i].e_wd));
      chk($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vt[i].e_rsp));
      chk($sformatf("v%0d_rsp_rdata", i), 32'(bus.rsp_rdata), 32'(vt[i].e_rd));
      next_cycle();
    end
    go_idle();
    next_cycle();

    // Full scrub with a read granted in the entry cycle and a write held pending.
    fill_ff();
    bus.clr_req = 1'b1;
    drive(2'b10, 2'b00, 4'h0, 4'h3, 8'h00, 8'h00);
    @(negedge clk);
    chk("scrub_entry_ready", 32'(bus.req_ready), 32'h2);
    chk("scrub_entry_ren", 32'(bus.ram_ren), 32'h1);
    chk("scrub_entry_busy", 32'(bus.clr_busy), 32'h0);
    next_cycle();
    bus.clr_req = 1'b0;
    drive(2'b01, 2'b01, 4'h9, 4'h0, 8'h55, 8'h00);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk("scrub_busy", 32'(bus.clr_busy), 32'h1);
      chk("scrub_waddr", 32'(bus.ram_waddr), 32'(k));
      chk("scrub_wdata", 32'(bus.ram_wdata), 32'h0);
      chk("scrub_wen_cs", 32'({bus.ram_wen, bus.ram_cs}), 32'h3);
      chk("scrub_ren", 32'(bus.ram_ren), 32'h0);
      chk("scrub_ready", 32'(bus.req_ready), 32'h0);
      chk("scrub_done_low", 32'(bus.clr_done), 32'h0);
      chk("scrub_rsp_valid", 32'(bus.rsp_valid), (k == 0) ? 32'h2 : 32'h0);
      if (k == 0) chk("scrub_entry_rdata", 32'(bus.rsp_rdata), 32'hFF);
      next_cycle();
      bus.clr_req = (k < 13);
      if (k == DEPTH - 1) go_idle();
    end
    @(negedge clk);
    chk("scrub_exit_busy", 32'(bus.clr_busy), 32'h0);
    chk("scrub_done_pulse", 32'(bus.clr_done), 32'h1);
    chk("scrub_exit_cs", 32'(bus.ram_cs), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("scrub_done_cleared", 32'(bus.clr_done), 32'h0);
    next_cycle();
    read_all(DEPTH, 8'h00, 8'h00);

    // Reset while the scrub is about to write address 7.
    fill_ff();
    bus.clr_req = 1'b1;
    next_cycle();
    bus.clr_req = 1'b0;
    repeat (7) next_cycle();
    @(negedge clk);
    chk("abort_waddr", 32'(bus.ram_waddr), 32'h7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.clr_busy), 32'h0);
    chk("abort_wen_cs", 32'({bus.ram_wen, bus.ram_cs}), 32'h0);
    chk("abort_waddr_zero", 32'(bus.ram_waddr), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", 32'(bus.clr_done), 32'h0);
    chk("abort_idle_busy", 32'(bus.clr_busy), 32'h0);
    chk("abort_idle_cs", 32'(bus.ram_cs), 32'h0);
    next_cycle();
    read_all(7, 8'h00, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
